// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port-A arbiter: requester ids,
// response tag layout and the default starvation limit.
package mem_arb_pkg;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  localparam int MAX_WAIT_DEF = 8;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/mem_arb_starve_guard.sv
// Starvation guard for the loader requester: counts lost arbitration cycles
// and raises force_r1 so the loader wins after MAX_WAIT consecutive losses.
module mem_arb_starve_guard
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic r1_valid,
  input  logic r1_ready,
  output logic force_r1
);

  localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;
  logic       waiting;

  assign waiting = r1_valid & ~r1_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      force_r1 <= 1'b0;
    end else begin
      if (!waiting)
        wait_cnt <= '0;
      else if (wait_cnt != MAX_W8)
        wait_cnt <= wait_cnt + 8'd1;
      // Force lands on the cycle after the MAX_WAIT-th loss
      if (r1_ready)
        force_r1 <= 1'b0;
      else if (waiting && (wait_cnt == MAX_W8 - 8'd1))
        force_r1 <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Port-A arbiter for the unified memory: core (r0) over loader (r1), with an
// optional loader starvation guard enabled by MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [3:0]        r0_we,
  input  logic [31:0]       r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [3:0]        r1_we,
  input  logic [31:0]       r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("mem_port_arbiter: MAX_WAIT must be within 1..255");
  end
  if (DATA_W != 32) begin : g_bad_data_w
    $error("mem_port_arbiter: only DATA_W=32 is supported");
  end

  logic force_r1;
  logic grant0;
  logic grant1;
  tag_t tag_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_guard #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_guard (
    .clk      (clk),
    .reset    (reset),
    .r1_valid (r1_valid),
    .r1_ready (grant1),
    .force_r1 (force_r1)
  );
`else
  assign force_r1 = 1'b0;
`endif

  // Request stage: grant and port-A mux; readies are held low during reset
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset) begin
      if (force_r1 && r1_valid)
        grant1 = 1'b1;
      else if (r0_valid)
        grant0 = 1'b1;
      else if (r1_valid)
        grant1 = 1'b1;
    end
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;
  assign mem_en   = grant0 | grant1;
  assign mem_we   = grant1 ? r1_we : (grant0 ? r0_we : 4'h0);
  assign mem_addr = grant1 ? r1_addr : r0_addr;
  assign mem_din  = grant1 ? r1_wdata : r0_wdata;

  // Response stage: tag follows the memory's one-cycle read latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q <= '0;
    end else begin
      tag_q.valid <= grant0 | grant1;
      tag_q.id    <= grant1 ? REQ_LOADER : REQ_CORE;
    end
  end

  assign r0_rvalid = tag_q.valid && (tag_q.id == REQ_CORE);
  assign r1_rvalid = tag_q.valid && (tag_q.id == REQ_LOADER);
  assign r0_rdata  = mem_dout;
  assign r1_rdata  = mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter, including a memory model
// on port A and a reference arbitration model (MEM_ARB_STARVE_GUARD_EN aware).
module tb_mem_port_arbiter;

  localparam int MW = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        r0_valid = 1'b0, r1_valid = 1'b0;
  logic        r0_ready, r1_ready;
  logic [3:0]  r0_we = '0, r1_we = '0;
  logic [31:0] r0_addr = '0, r1_addr = '0;
  logic [31:0] r0_wdata = '0, r1_wdata = '0;
  logic        r0_rvalid, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_din;
  logic [31:0] mem_dout = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_WAIT(MW), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  typedef struct {
    int          due;
    bit          is_rd;
    logic [31:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] mem_arr [64];
  logic [31:0] ref_mem [64];

  function automatic logic [31:0] init_val(input int i);
    return 32'(i) * 32'h0101_0101 ^ 32'hA5C3_0F96;
  endfunction

  // Port-A memory: read-first, byte write enables, one-cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= init_val(i);
    end else if (mem_en) begin
      mem_dout <= mem_arr[mem_addr[7:2]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem_arr[mem_addr[7:2]][8*b +: 8] <= mem_din[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response pulse appears
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("rst_r0_ready", 32'(r0_ready), 32'd0);
      chk("rst_r1_ready", 32'(r1_ready), 32'd0);
      chk("rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
      chk("rst_r1_rvalid", 32'(r1_rvalid), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
    end else begin
      if (r0_rvalid) begin
        if (q0.size() == 0) chk("r0_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          chk("r0_rvalid_cycle", 32'(cyc), 32'(e.due));
          if (e.is_rd) chk("r0_rdata", r0_rdata, e.data);
        end
      end else if (q0.size() != 0 && q0[0].due <= cyc) begin
        chk("r0_rvalid_missing", 32'd0, 32'd1);
        void'(q0.pop_front());
      end
      if (r1_rvalid) begin
        if (q1.size() == 0) chk("r1_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("r1_rvalid_cycle", 32'(cyc), 32'(e.due));
          if (e.is_rd) chk("r1_rdata", r1_rdata, e.data);
        end
      end else if (q1.size() != 0 && q1[0].due <= cyc) begin
        chk("r1_rvalid_missing", 32'd0, 32'd1);
        void'(q1.pop_front());
      end
    end
  end

  // Reference model state: pending request per requester and r1 lost-cycle count
  bit          pend0 = 0, pend1 = 0;
  logic [3:0]  we0 = '0, we1 = '0;
  logic [31:0] a0 = '0, a1 = '0, d0 = '0, d1 = '0;
  int          waited = 0;
  bit          rd_only = 0;

  task automatic new_req(output logic [3:0] we, output logic [31:0] a, output logic [31:0] d);
    a  = {24'h0, 6'($urandom_range(63)), 2'b00};
    we = (rd_only || $urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
    d  = $urandom;
  endtask

  task automatic issue(input bit id, input logic [3:0] we, input logic [31:0] a,
                       input logic [31:0] d);
    exp_t e;
    int   idx;
    idx     = int'(a[7:2]);
    e.due   = cyc + 1;
    e.is_rd = (we == 4'h0);
    e.data  = ref_mem[idx];
    for (int b = 0; b < 4; b++)
      if (we[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    if (id) q1.push_back(e);
    else    q0.push_back(e);
  endtask

  task automatic step(input int p0, input int p1);
    bit g0, g1;
    @(posedge clk); #1;
    if (!pend0 && $urandom_range(99) < p0) begin new_req(we0, a0, d0); pend0 = 1; end
    if (!pend1 && $urandom_range(99) < p1) begin new_req(we1, a1, d1); pend1 = 1; end
    r0_valid = pend0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
    r1_valid = pend1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
    @(negedge clk);
    g1 = pend1 && ((GUARD && waited >= MW) || !pend0);
    g0 = pend0 && !g1;
    chk("r0_ready", 32'(r0_ready), 32'(g0));
    chk("r1_ready", 32'(r1_ready), 32'(g1));
    chk("mem_en", 32'(mem_en), 32'(g0 | g1));
    if (!(g0 | g1)) chk("mem_we_idle", 32'(mem_we), 32'd0);
    if (g0) begin
      chk("mem_addr_r0", mem_addr, a0);
      chk("mem_we_r0", 32'(mem_we), 32'(we0));
      if (we0 != 4'h0) chk("mem_din_r0", mem_din, d0);
      issue(1'b0, we0, a0, d0);
      pend0 = 0;
    end
    if (g1) begin
      chk("mem_addr_r1", mem_addr, a1);
      chk("mem_we_r1", 32'(mem_we), 32'(we1));
      if (we1 != 4'h0) chk("mem_din_r1", mem_din, d1);
      if (GUARD) chk("r1_wait_bound", 32'(waited <= MW), 32'd1);
      issue(1'b1, we1, a1, d1);
    end
    if (g1 || !pend1) waited = 0;
    else waited++;
    if (g1) pend1 = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (pend0 || pend1); i++) step(0, 0);
    chk("drain_done", 32'(pend0 | pend1), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    reset = 1'b1;

    repeat (3) step(0, 0);
    repeat (400) step(50, 50);
    repeat (60) step(100, 40);
    drain();
    repeat (200) step(30, 70);
    drain();

    // Loader read accepted, then reset lands before its response
    rd_only = 1;
    step(0, 100);
    @(posedge clk); #1;
    reset = 1'b0;
    q0.delete(); q1.delete();
    pend0 = 0; pend1 = 0; waited = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    reset = 1'b1;

    step(0, 100);
    step(100, 0);
    drain();
    rd_only = 0;
    repeat (100) step(60, 60);
    drain();
    repeat (4) step(0, 0);

    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter for the general-use port (port A) of the unified memory. Sits between the core load/store unit (requester 0) and the debug/program-loader master (requester 1), and drives the memory's port-A request signals. Accepts at most one request per cycle. Routes the memory's one-cycle-latency read data back to whichever requester issued it. Memory-mapped IO addresses (output buffer at 32'h8000_0000/32'h8000_0004) pass through unchanged; the arbiter does not decode addresses.

## Interface
- MAX_WAIT, default 8: cycles requester 1 may wait before it is forced through. Range 1..255. Used only with the guard macro.
- DATA_W, default 32: data width. Only 32 is supported.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- r0_valid / r1_valid  in  1  request present.
- r0_ready / r1_ready  out  1  request accepted this cycle. Combinational.
- r0_we / r1_we  in  4  byte write enables; 0 means read.
- r0_addr / r1_addr  in  32  byte address.
- r0_wdata / r1_wdata  in  32  write data.
- r0_rvalid / r1_rvalid  out  1  response pulse: read data or write ack.
- r0_rdata / r1_rdata  out  32  response data; both are wired to mem_dout.
- mem_en  out  1  port-A enable.
- mem_we  out  4  port-A byte enables.
- mem_addr  out  32  port-A address.
- mem_din  out  32  port-A write data.
- mem_dout  in  32  port-A read data; valid the cycle after mem_en.

## Operation
- Grant logic (combinational) selects at most one requester per cycle:
  - force_r1 set: r1 is granted if r1_valid.
  - otherwise r0 is granted if r0_valid.
  - otherwise r1 is granted if r1_valid.
- Granted requester sees ready=1. The mem_* outputs mux the granted requester's fields, and mem_en=1.
- With no grant: mem_en=0, mem_we=0. mem_addr and mem_din hold the r0 fields (don't care).
- Tag register tag_q (2 bits: valid, id) records each grant. Next cycle it drives r{id}_rvalid=1. Every accepted request produces exactly one rvalid pulse, reads and writes alike.
- Responses have no back-pressure; requesters must take rvalid in the cycle it is asserted.
- Back-to-back accepts are allowed every cycle. Throughput is 1 request per cycle; requests stay in order per requester.
- Request fields must be held stable while valid=1 and ready=0. Deasserting valid before acceptance is allowed.
- Simultaneous r0_valid and r1_valid without force: r0 wins, r1 waits.
- While reset is low:
  - all ready, rvalid and mem_en outputs are 0.
  - tag_q=0, wait_cnt=0, force_r1=0.
- Reset asserted with a response pending: the response is dropped and no rvalid follows.

## Timing
- Cycle N: valid & ready, so mem_en=1 with the request fields.
- Cycle N+1: mem_dout is valid. r{id}_rvalid=1 and r{id}_rdata=mem_dout.
- Latency from accept to rvalid is exactly 1 cycle.
- Outputs after reset deassertion: all 0 until the first valid request arrives.
- wait_cnt (8 bits): increments each cycle r1_valid & !r1_ready. It clears when r1 is granted or r1_valid=0, and saturates at MAX_WAIT.
- force_r1: registered, set when wait_cnt reaches MAX_WAIT-1 while still waiting. It clears in the cycle r1 is accepted.
- MAX_WAIT=1: force is set after a single lost cycle.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: wait_cnt and force_r1 are present.
  - r1 is granted no later than MAX_WAIT+1 cycles after first asserting valid, even under continuous r0 traffic.
- MEM_ARB_STARVE_GUARD_EN undefined: strict fixed priority to r0.
  - wait_cnt and force_r1 are not built (force_r1 tied 0).
  - r1 can starve indefinitely.

## Structure
- Shared package mem_arb_pkg holds:
  - requester id constants REQ_CORE=0 and REQ_LOADER=1.
  - the tag struct {valid, id}.
  - the default MAX_WAIT.
- One sub-module, mem_arb_starve_guard, holds wait_cnt and force_r1. It is instantiated only under the macro.
- All other logic lives in the top module.

## Test plan
- Single read: r0 reads addr 0x10 holding 0xDEADBEEF. Required: r0_ready=1 and mem_en=1 in the request cycle; r0_rvalid=1 with rdata 0xDEADBEEF one cycle later; r1_rvalid=0 throughout.
- Simultaneous requests, no force: r0 writes 0x11223344 (we=4'hF) to 0x20, r1 reads 0x20 in the same cycle. Required: r0 is accepted first; r1 is accepted the next cycle and its rvalid returns 0x11223344.
- Back-to-back: r0 issues 4 consecutive reads of 0x0, 0x4, 0x8, 0xC. Required: 4 consecutive accepts, then 4 consecutive r0_rvalid pulses with data in order.
- Starvation guard (macro on, MAX_WAIT=4): r0_valid is held 1 continuously and r1 raises valid. Required: r1 is accepted on its 5th waiting cycle; r0_ready=0 in that cycle; r0 resumes the cycle after.
- Guard off (macro undefined): same stimulus held for 100 cycles. Required: r1_ready stays 0 for all 100 cycles.
- Reset mid-flight: r1 read accepted, then reset driven low on the next edge. Required: no r1_rvalid; all outputs 0 until reset deasserts; the first post-reset request completes normally.
